// File: rtl/lcd_ctrl_win.sv
// LCD window controller: serial frame load, movable cursor, WIN x WIN raster window output.
// Optional window-maximum command 7 is built only when LCD_CTRL_STAT_EN is defined.
module lcd_ctrl_win #(
    parameter int DW    = 8,
    parameter int IMG_W = 6,
    parameter int IMG_H = 6,
    parameter int WIN   = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [DW-1:0] datain,
    input  logic [2:0]    cmd,
    input  logic          cmd_valid,
    output logic [DW-1:0] dataout,
    output logic          output_valid,
    output logic          busy
);
    localparam int R    = WIN / 2;
    localparam int NPIX = IMG_W * IMG_H;
    localparam int CW   = $clog2(IMG_W > IMG_H ? IMG_W : IMG_H);
    localparam int AW   = $clog2(NPIX);
    localparam int WW   = $clog2(WIN + 1);
    localparam int XMAX = IMG_W - 1 - R;
    localparam int YMAX = IMG_H - 1 - R;
    localparam int CX0  = (IMG_W / 2 < R) ? R : ((IMG_W / 2 > XMAX) ? XMAX : IMG_W / 2);
    localparam int CY0  = (IMG_H / 2 < R) ? R : ((IMG_H / 2 > YMAX) ? YMAX : IMG_H / 2);
    localparam logic [CW-1:0] CX = CW'(CX0);
    localparam logic [CW-1:0] CY = CW'(CY0);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_MOVE, S_OUT, S_STAT, S_STAT_OUT
    } state_t;

    state_t state, state_n;

    logic [DW-1:0] mem [NPIX];
    logic [CW-1:0] cur_x, cur_y;
    logic [WW-1:0] wr, wc;
    logic [AW-1:0] ld_cnt;
    logic [2:0]    cmd_r;
    logic [31:0]   row, col;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_pix;
    logic          win_last, ld_last;
`ifdef LCD_CTRL_STAT_EN
    logic [DW-1:0] max_r;
`endif

    // Cursor is always clamped to [R, limit], so row/col never go negative.
    assign row      = 32'(cur_y) + 32'(wr) - 32'(R);
    assign col      = 32'(cur_x) + 32'(wc) - 32'(R);
    assign rd_addr  = AW'(row * 32'(IMG_W) + col);
    assign rd_pix   = mem[rd_addr];
    assign win_last = (wr == WW'(WIN - 1)) && (wc == WW'(WIN - 1));
    assign ld_last  = (ld_cnt == AW'(NPIX - 1));
    assign busy     = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (state == S_LOAD)
            mem[ld_cnt] <= datain;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= S_IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE: begin
                if (cmd_valid) begin
                    case (cmd)
                        3'd0:    state_n = S_OUT;
                        3'd1:    state_n = S_LOAD;
`ifdef LCD_CTRL_STAT_EN
                        3'd7:    state_n = S_STAT;
`else
                        3'd7:    state_n = S_IDLE;
`endif
                        default: state_n = S_MOVE;
                    endcase
                end
            end
            S_LOAD:     if (ld_last) state_n = S_OUT;
            S_MOVE:     state_n = S_OUT;
            S_OUT:      if (win_last) state_n = S_IDLE;
`ifdef LCD_CTRL_STAT_EN
            S_STAT:     if (win_last) state_n = S_STAT_OUT;
            S_STAT_OUT: state_n = S_IDLE;
`endif
            default:    state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_x        <= CX;
            cur_y        <= CY;
            dataout      <= '0;
            output_valid <= 1'b0;
            wr           <= '0;
            wc           <= '0;
            ld_cnt       <= '0;
            cmd_r        <= '0;
`ifdef LCD_CTRL_STAT_EN
            max_r        <= '0;
`endif
        end else begin
            output_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    wr     <= '0;
                    wc     <= '0;
                    ld_cnt <= '0;
                    if (cmd_valid) cmd_r <= cmd;
                end
                S_LOAD: begin
                    ld_cnt <= ld_cnt + 1'b1;
                    if (ld_last) begin
                        cur_x <= CX;
                        cur_y <= CY;
                    end
                end
                S_MOVE: begin
                    case (cmd_r)
                        3'd2: if (cur_x < CW'(XMAX)) cur_x <= cur_x + 1'b1;
                        3'd3: if (cur_x > CW'(R))    cur_x <= cur_x - 1'b1;
                        3'd4: if (cur_y > CW'(R))    cur_y <= cur_y - 1'b1;
                        3'd5: if (cur_y < CW'(YMAX)) cur_y <= cur_y + 1'b1;
                        3'd6: begin
                            cur_x <= CX;
                            cur_y <= CY;
                        end
                        default: ;
                    endcase
                end
                S_OUT: begin
                    dataout      <= rd_pix;
                    output_valid <= 1'b1;
                    if (wc == WW'(WIN - 1)) begin
                        wc <= '0;
                        wr <= wr + 1'b1;
                    end else begin
                        wc <= wc + 1'b1;
                    end
                end
`ifdef LCD_CTRL_STAT_EN
                S_STAT: begin
                    if ((wr == '0 && wc == '0) || rd_pix > max_r)
                        max_r <= rd_pix;
                    if (wc == WW'(WIN - 1)) begin
                        wc <= '0;
                        wr <= wr + 1'b1;
                    end else begin
                        wc <= wc + 1'b1;
                    end
                end
                S_STAT_OUT: begin
                    dataout      <= max_r;
                    output_valid <= 1'b1;
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_ctrl_win.sv
// Bench for lcd_ctrl_win: directed and random commands against a frame/cursor model.
module tb_lcd_ctrl_win;
    localparam int DW    = 8;
    localparam int IMG_W = 6;
    localparam int IMG_H = 6;
    localparam int WIN   = 3;
    localparam int R     = WIN / 2;
    localparam int N     = WIN * WIN;
    localparam int NPIX  = IMG_W * IMG_H;
    localparam int XMAX  = IMG_W - 1 - R;
    localparam int YMAX  = IMG_H - 1 - R;
    localparam int CXM   = (IMG_W / 2 < R) ? R : ((IMG_W / 2 > XMAX) ? XMAX : IMG_W / 2);
    localparam int CYM   = (IMG_H / 2 < R) ? R : ((IMG_H / 2 > YMAX) ? YMAX : IMG_H / 2);

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] datain;
    logic [2:0]    cmd;
    logic          cmd_valid;
    logic [DW-1:0] dataout;
    logic          output_valid;
    logic          busy;

    int total = 0;
    int bad   = 0;
    int mem_m  [NPIX];
    int newimg [NPIX];
    int cx, cy;

    lcd_ctrl_win #(.DW(DW), .IMG_W(IMG_W), .IMG_H(IMG_H), .WIN(WIN)) dut (
        .clk(clk), .reset(reset), .datain(datain), .cmd(cmd), .cmd_valid(cmd_valid),
        .dataout(dataout), .output_valid(output_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int win_pix(input int i);
        return mem_m[(cy - R + i / WIN) * IMG_W + (cx - R + i % WIN)];
    endfunction

    function automatic void model_move(input int c);
        case (c)
            2: if (cx < XMAX) cx++;
            3: if (cx > R) cx--;
            4: if (cy > R) cy--;
            5: if (cy < YMAX) cy++;
            6: begin cx = CXM; cy = CYM; end
            default: ;
        endcase
    endfunction

    // Called at a falling edge while idle; returns at the falling edge after the
    // last output (busy already low), so an immediate next call is back-to-back.
    task automatic do_cmd(input int c, input bit glitch);
        int mx;
        chk("idle_busy", 32'(busy), 0);
        cmd = 3'(c);
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        if (c == 7) begin
`ifdef LCD_CTRL_STAT_EN
            mx = 0;
            for (int i = 0; i < N; i++) if (win_pix(i) > mx) mx = win_pix(i);
            for (int i = 0; i <= N; i++) begin
                chk("stat_busy", 32'(busy), 1);
                chk("stat_nov", 32'(output_valid), 0);
                @(negedge clk);
            end
            chk("stat_valid", 32'(output_valid), 1);
            chk("stat_max", 32'(dataout), 32'(mx));
            chk("stat_busy_low", 32'(busy), 0);
`else
            for (int i = 0; i < N + 2; i++) begin
                chk("nostat_busy", 32'(busy), 0);
                chk("nostat_nov", 32'(output_valid), 0);
                @(negedge clk);
            end
`endif
            return;
        end
        chk("start_busy", 32'(busy), 1);
        chk("start_nov", 32'(output_valid), 0);
        if (glitch) begin
            cmd_valid = 1'b1;
            cmd = 3'd1;
        end
        if (c == 1) begin
            for (int k = 0; k < NPIX; k++) begin
                datain = DW'(newimg[k]);
                @(negedge clk);
                cmd_valid = 1'b0;
            end
            mem_m = newimg;
            cx = CXM;
            cy = CYM;
        end else if (c >= 2) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            model_move(c);
            chk("move_nov", 32'(output_valid), 0);
        end
        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            chk("win_valid", 32'(output_valid), 1);
            chk("win_pix", 32'(dataout), 32'(win_pix(i)));
            chk("win_busy", 32'(busy), (i < N - 1) ? 1 : 0);
        end
    endtask

    task automatic idle_chk(input int last);
        @(negedge clk);
        chk("idle_nov", 32'(output_valid), 0);
        chk("idle_busy", 32'(busy), 0);
        chk("idle_hold", 32'(dataout), 32'(last));
    endtask

    initial begin
        int c, gap;
        reset = 1'b1;
        datain = '0;
        cmd = '0;
        cmd_valid = 1'b0;
        cx = CXM;
        cy = CYM;
        @(negedge clk);
        chk("rst_dataout", 32'(dataout), 0);
        chk("rst_valid", 32'(output_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        reset = 1'b0;
        @(negedge clk);

        // Ramp load: centred window must be 14,15,16,20,21,22,26,27,28
        for (int k = 0; k < NPIX; k++) newimg[k] = k;
        do_cmd(1, 0);
        chk("ramp_centre_model", 32'(win_pix(0)), 14);
        idle_chk(28);

        // Two RIGHTs back-to-back, second clamps at x=4
        do_cmd(2, 0);
        do_cmd(2, 0);
        chk("right_clamp_x", 32'(cx), 4);
        idle_chk(29);

        // UP three times (clamp at y=1), then CENTRE
        do_cmd(6, 0);
        do_cmd(4, 0);
        do_cmd(4, 0);
        do_cmd(4, 0);
        idle_chk(16);
        do_cmd(6, 0);
        idle_chk(28);

        // Command pulsed while busy must be ignored
        do_cmd(0, 1);
        idle_chk(28);

        // Window maximum at cursor (3,1)
        do_cmd(4, 0);
        do_cmd(4, 0);
        idle_chk(16);
        do_cmd(7, 0);
        idle_chk(16);
        do_cmd(0, 0);
        idle_chk(16);

        // Random frames and command mix
        for (int k = 0; k < NPIX; k++) newimg[k] = int'($urandom_range(0, (1 << DW) - 1));
        do_cmd(1, 0);
        for (int t = 0; t < 40; t++) begin
            c = int'($urandom_range(0, 7));
            if (c == 1)
                for (int k = 0; k < NPIX; k++) newimg[k] = int'($urandom_range(0, (1 << DW) - 1));
            do_cmd(c, t[0]);
            gap = int'($urandom_range(0, 2));
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                chk("rand_gap_nov", 32'(output_valid), 0);
            end
        end
        @(negedge clk);

        // Reset during LOAD after 20 pixels; cursor moved off centre first
        for (int k = 0; k < NPIX; k++) newimg[k] = 100 + k;
        do_cmd(6, 0);
        do_cmd(3, 0);
        @(negedge clk);
        cmd = 3'd1;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int k = 0; k < 20; k++) begin
            datain = DW'(newimg[k]);
            @(negedge clk);
        end
        reset = 1'b1;
        #1;
        chk("midrst_dataout", 32'(dataout), 0);
        chk("midrst_valid", 32'(output_valid), 0);
        chk("midrst_busy", 32'(busy), 0);
        for (int k = 0; k < 20; k++) mem_m[k] = newimg[k];
        cx = CXM;
        cy = CYM;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        do_cmd(0, 0);
        chk("midrst_new14", 32'(win_pix(0)), 114);
        idle_chk(win_pix(N - 1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
